icache_ctrl: RTL and testbench



---
 rtl/icache_pkg.sv | 31 +++
 rtl/icache_ctrl_if.sv | 26 ++
 rtl/icache_array.sv | 49 ++++
 rtl/icache_ctrl.sv | 132 +++++++++++++
 tb/tb_icache_ctrl.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// Shared types, default address split and address-field helpers for the instruction cache.
package icache_pkg;

    localparam int DEF_ADDR_W     = 32;
    localparam int DEF_LINE_WORDS = 4;
    localparam int DEF_NUM_LINES  = 64;

    localparam int WORD_W = $clog2(DEF_LINE_WORDS);
    localparam int OFF_W  = WORD_W + 2;
    localparam int IDX_W  = $clog2(DEF_NUM_LINES);
    localparam int TAG_W  = DEF_ADDR_W - OFF_W - IDX_W;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ    = 2'd1,
        REFILL = 2'd2
    } state_t;

    function automatic logic [IDX_W-1:0] get_idx(input logic [DEF_ADDR_W-1:0] addr);
        return IDX_W'(addr >> OFF_W);
    endfunction

    function automatic logic [TAG_W-1:0] get_tag(input logic [DEF_ADDR_W-1:0] addr);
        return TAG_W'(addr >> (OFF_W + IDX_W));
    endfunction

    function automatic logic [WORD_W-1:0] get_word(input logic [DEF_ADDR_W-1:0] addr);
        return WORD_W'(addr >> 2);
    endfunction

endpackage

// File: rtl/icache_ctrl_if.sv
// Line-refill bus between the instruction cache (master) and instruction memory (slave).
interface icache_ctrl_if #(
    parameter int ADDR_W = 32
);
    logic              mem_rd_req;
    logic [ADDR_W-1:0] mem_rd_addr;
    logic              mem_rd_gnt;
    logic              mem_rd_valid;
    logic [31:0]       mem_rd_data;

    modport master (
        output mem_rd_req,
        output mem_rd_addr,
        input  mem_rd_gnt,
        input  mem_rd_valid,
        input  mem_rd_data
    );

    modport slave (
        input  mem_rd_req,
        input  mem_rd_addr,
        output mem_rd_gnt,
        output mem_rd_valid,
        output mem_rd_data
    );
endinterface

// File: rtl/icache_array.sv
// Direct-mapped storage: valid bits in resettable flops, tag/data arrays with combinational read.
module icache_array #(
    parameter int NUM_LINES  = 64,
    parameter int LINE_WORDS = 4,
    parameter int TAG_BITS   = 22
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          inv,
    input  logic [$clog2(NUM_LINES)-1:0]  rd_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic                          rd_valid,
    output logic [TAG_BITS-1:0]           rd_tag,
    output logic [31:0]                   rd_data,
    input  logic                          wr_en,
    input  logic [$clog2(NUM_LINES)-1:0]  wr_idx,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [31:0]                   wr_data,
    input  logic                          tag_wr,
    input  logic [TAG_BITS-1:0]           wr_tag
);
    logic [NUM_LINES-1:0] valid;
    logic [TAG_BITS-1:0]  tags [NUM_LINES];
    logic [31:0]          data [NUM_LINES][LINE_WORDS];

    // Invalidate wins over the line-complete set, so a fence.i on the last beat leaves the line invalid.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid <= '0;
        end else if (inv) begin
            valid <= '0;
        end else if (tag_wr) begin
            valid[wr_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data[wr_idx][wr_word] <= wr_data;
        end
        if (tag_wr) begin
            tags[wr_idx] <= wr_tag;
        end
    end

    assign rd_valid = valid[rd_idx];
    assign rd_tag   = tags[rd_idx];
    assign rd_data  = data[rd_idx][rd_word];
endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped read-only I-cache controller for the IF stage; hit returns InstrF same cycle.
// Optional macro ICACHE_PERF_EN adds HitCnt/MissCnt performance counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int LINE_WORDS = DEF_LINE_WORDS,
    parameter int NUM_LINES  = DEF_NUM_LINES
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              RdEnF,
    input  logic [ADDR_W-1:0] PcF,
    output logic [31:0]       InstrF,
    output logic              ICacheMiss,
    input  logic              Inv,
`ifdef ICACHE_PERF_EN
    output logic [31:0]       HitCnt,
    output logic [31:0]       MissCnt,
`endif
    icache_ctrl_if.master     mem
);
    localparam int WRD_B  = $clog2(LINE_WORDS);
    localparam int OFF_B  = WRD_B + 2;
    localparam int IDX_B  = $clog2(NUM_LINES);
    localparam int LINE_B = ADDR_W - OFF_B;
    localparam int TAG_B  = LINE_B - IDX_B;
    localparam logic [WRD_B-1:0] LAST_BEAT = WRD_B'(LINE_WORDS - 1);

    state_t            state;
    state_t            state_next;
    logic [LINE_B-1:0] miss_line;
    logic [WRD_B-1:0]  beat_cnt;
    logic [IDX_B-1:0]  pc_idx;
    logic [TAG_B-1:0]  pc_tag;
    logic [WRD_B-1:0]  pc_word;
    logic [TAG_B-1:0]  line_tag;
    logic              line_valid;
    logic              hit;
    logic              miss_start;
    logic              beat_wr;
    logic              last_wr;
    logic              unused_pc;

    assign pc_word    = PcF[OFF_B-1:2];
    assign pc_idx     = PcF[OFF_B+IDX_B-1:OFF_B];
    assign pc_tag     = PcF[ADDR_W-1:OFF_B+IDX_B];
    assign unused_pc  = ^PcF[1:0];
    assign hit        = line_valid && (line_tag == pc_tag);
    assign miss_start = (state == IDLE) && RdEnF && !hit;

    icache_array #(
        .NUM_LINES  (NUM_LINES),
        .LINE_WORDS (LINE_WORDS),
        .TAG_BITS   (TAG_B)
    ) u_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .inv      (Inv),
        .rd_idx   (pc_idx),
        .rd_word  (pc_word),
        .rd_valid (line_valid),
        .rd_tag   (line_tag),
        .rd_data  (InstrF),
        .wr_en    (beat_wr),
        .wr_idx   (miss_line[IDX_B-1:0]),
        .wr_word  (beat_cnt),
        .wr_data  (mem.mem_rd_data),
        .tag_wr   (last_wr),
        .wr_tag   (miss_line[LINE_B-1:IDX_B])
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (miss_start)      state_next = REQ;
            REQ:     if (mem.mem_rd_gnt)  state_next = REFILL;
            REFILL:  if (last_wr)         state_next = IDLE;
            default:                      state_next = IDLE;
        endcase
    end

    always_comb begin
        ICacheMiss     = miss_start || (state != IDLE);
        mem.mem_rd_req = (state == REQ);
        beat_wr        = (state == REFILL) && mem.mem_rd_valid;
        last_wr        = beat_wr && (beat_cnt == LAST_BEAT);
    end

    // The line address is frozen at miss detection; PcF is free to move during the refill.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            miss_line <= '0;
            beat_cnt  <= '0;
        end else begin
            if (miss_start) begin
                miss_line <= PcF[ADDR_W-1:OFF_B];
            end
            if ((state == REQ) && mem.mem_rd_gnt) begin
                beat_cnt <= '0;
            end else if (beat_wr) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
        end
    end

    assign mem.mem_rd_addr = {miss_line, {OFF_B{1'b0}}};

`ifdef ICACHE_PERF_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            HitCnt  <= '0;
            MissCnt <= '0;
        end else begin
            if ((state == IDLE) && RdEnF && hit) begin
                HitCnt <= HitCnt + 32'd1;
            end
            if (miss_start) begin
                MissCnt <= MissCnt + 32'd1;
            end
        end
    end
`endif
endmodule

// File: tb/tb_icache_ctrl.sv
// Scoreboard bench for icache_ctrl: directed fetches push expected words/refill addresses, a monitor checks them.
module tb_icache_ctrl;
    import icache_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        RdEnF = 1'b0;
    logic [31:0] PcF = 32'h0;
    logic [31:0] InstrF;
    logic        ICacheMiss;
    logic        Inv;
    logic        inv_main = 1'b0;
    logic        inv_mem = 1'b0;
    logic        gnt_drv = 1'b0;
    logic        vld_drv = 1'b0;
    logic [31:0] data_drv = 32'h0;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt;
    logic [31:0] miss_cnt;
`endif

    int checks = 0;
    int failures = 0;
    logic [31:0] exp_instr[$];
    logic [31:0] exp_addr[$];

    icache_ctrl_if #(.ADDR_W(32)) bus ();

    assign Inv              = inv_main | inv_mem;
    assign bus.mem_rd_gnt   = gnt_drv;
    assign bus.mem_rd_valid = vld_drv;
    assign bus.mem_rd_data  = data_drv;

    icache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .RdEnF      (RdEnF),
        .PcF        (PcF),
        .InstrF     (InstrF),
        .ICacheMiss (ICacheMiss),
        .Inv        (Inv),
`ifdef ICACHE_PERF_EN
        .HitCnt     (hit_cnt),
        .MissCnt    (miss_cnt),
`endif
        .mem        (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    function automatic logic [31:0] line_of(input logic [31:0] a);
        return (32'(get_tag(a)) << (OFF_W + IDX_W)) | (32'(get_idx(a)) << OFF_W);
    endfunction

    // Memory side: waits for a request, grants after gnt_dly cycles, streams base..base+3.
    task automatic mem_serve(input logic [31:0] base, input int gnt_dly, input int gap,
                             input bit inv_last, input logic [31:0] line_addr);
        for (int i = 0; i < 40 && !bus.mem_rd_req; i++) begin
            @(posedge clk); #1;
        end
        if (!bus.mem_rd_req) begin
            checks++;
            failures++;
            $display("FAIL mem_req_timeout actual=0 required=1");
            return;
        end
        for (int i = 0; i < gnt_dly; i++) begin
            check("req_held", 32'(bus.mem_rd_req), 32'd1);
            check("req_addr_stable", bus.mem_rd_addr, line_addr);
            @(posedge clk); #1;
        end
        gnt_drv = 1'b1;
        @(posedge clk); #1;
        gnt_drv = 1'b0;
        for (int b = 0; b < 4; b++) begin
            if (b == 2) begin
                for (int g = 0; g < gap; g++) begin
                    vld_drv = 1'b0;
                    @(posedge clk); #1;
                end
            end
            vld_drv  = 1'b1;
            data_drv = base + 32'(b);
            inv_mem  = inv_last && (b == 3);
            @(posedge clk); #1;
        end
        vld_drv = 1'b0;
        inv_mem = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 with RdEnF dropped after the word is delivered.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] base, input int miss_cyc,
                         input int gnt_dly, input int gap, input bit inv_last);
        int  cyc;
        bit  done;
        logic [31:0] la;
        la    = line_of(addr);
        PcF   = addr;
        RdEnF = 1'b1;
        exp_instr.push_back((inv_last ? base + 32'h10 : base) + 32'(get_word(addr)));
        if (miss_cyc != 0) begin
            exp_addr.push_back(la);
            if (inv_last) exp_addr.push_back(la);
            fork
                begin
                    mem_serve(base, gnt_dly, gap, inv_last, la);
                    if (inv_last) mem_serve(base + 32'h10, 0, 0, 1'b0, la);
                end
            join_none
        end
        cyc  = 0;
        done = 1'b0;
        for (int i = 0; i < 60 && !done; i++) begin
            @(negedge clk);
            if (ICacheMiss) cyc++;
            else done = 1'b1;
        end
        check("miss_cycles", 32'(cyc), 32'(miss_cyc));
        check("req_idle_at_delivery", 32'(bus.mem_rd_req), 32'd0);
        @(posedge clk); #1;
        RdEnF = 1'b0;
    endtask

    initial begin
        logic [31:0] e;
        forever begin
            @(negedge clk);
            if (rst_n && RdEnF && !ICacheMiss) begin
                if (exp_instr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL instr_unexpected actual=%h required=none", InstrF);
                end else begin
                    e = exp_instr.pop_front();
                    check("InstrF", InstrF, e);
                end
            end
            if (rst_n && bus.mem_rd_req && bus.mem_rd_gnt) begin
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL refill_unexpected actual=%h required=none", bus.mem_rd_addr);
                end else begin
                    e = exp_addr.pop_front();
                    check("mem_rd_addr", bus.mem_rd_addr, e);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_miss", 32'(ICacheMiss), 32'd0);
        check("rst_req", 32'(bus.mem_rd_req), 32'd0);
        check("rst_addr", bus.mem_rd_addr, 32'h0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("idle_no_rden_miss", 32'(ICacheMiss), 32'd0);
        @(posedge clk); #1;

        // Cold miss, hit, conflict eviction
        fetch(32'h100, 32'hA0, 6, 0, 0, 1'b0);
        fetch(32'h108, 32'hA0, 0, 0, 0, 1'b0);
        fetch(32'h500, 32'hB0, 6, 0, 0, 1'b0);
        fetch(32'h100, 32'hA0, 6, 0, 0, 1'b0);

        // Delayed grant and a gap between beats 1 and 2
        fetch(32'h30C, 32'hC0, 11, 3, 2, 1'b0);
        fetch(32'h300, 32'hC0, 0, 0, 0, 1'b0);
        fetch(32'h304, 32'hC0, 0, 0, 0, 1'b0);
        fetch(32'h308, 32'hC0, 0, 0, 0, 1'b0);

        // Reset after beat 1 of a refill; later beats are stray
        PcF   = 32'h200;
        RdEnF = 1'b1;
        exp_addr.push_back(32'h200);
        fork
            mem_serve(32'h77, 0, 0, 1'b0, 32'h200);
        join_none
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        RdEnF = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("abort_req", 32'(bus.mem_rd_req), 32'd0);
        check("abort_miss", 32'(ICacheMiss), 32'd0);
        check("abort_addr", bus.mem_rd_addr, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        fetch(32'h100, 32'hA0, 6, 0, 0, 1'b0);
        fetch(32'h200, 32'hD0, 6, 0, 0, 1'b0);

        // Invalidate while idle, then invalidate on the last refill beat
        inv_main = 1'b1;
        @(posedge clk); #1;
        inv_main = 1'b0;
        fetch(32'h104, 32'hE0, 6, 0, 0, 1'b0);
        fetch(32'h400, 32'hF0, 12, 0, 0, 1'b1);
        fetch(32'h404, 32'h100, 0, 0, 0, 1'b0);

        repeat (3) @(posedge clk);
        check("instr_queue_drained", 32'(exp_instr.size()), 32'd0);
        check("addr_queue_drained", 32'(exp_addr.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
